// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - I2C register read/write sequencer driving a byte-level bit-shift stage
// Turns single register requests into START/address/data/STOP byte commands.
module i2c_reg_ctrl #(
   parameter logic [6:0] DEV_ADDR = 7'h50
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        wrreg_req,
   input  logic        rdreg_req,
   input  logic [15:0] addr,
   input  logic        addr_mode,
   input  logic [7:0]  wrdata,
   output logic [7:0]  rddata,
   output logic        RW_Done,
   output logic        ack,
   output logic        busy,
   output logic [5:0]  Cmd,
   output logic        Go,
   output logic [7:0]  Tx_DATA,
   input  logic [7:0]  Rx_DATA,
   input  logic        Trans_Done,
   input  logic        ack_o
);

   localparam logic [5:0] CMD_WR   = 6'b000001;
   localparam logic [5:0] CMD_STA  = 6'b000010;
   localparam logic [5:0] CMD_RD   = 6'b000100;
   localparam logic [5:0] CMD_STO  = 6'b001000;
   localparam logic [5:0] CMD_NACK = 6'b100000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        rd_mode_q, rd_mode_d;
   logic        mode16_q, mode16_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wrdata_q, wrdata_d;
   logic [7:0]  rddata_q, rddata_d;
   logic        ack_q, ack_d;

   logic [2:0]  step;
   logic [5:0]  cmd_cur;
   logic [7:0]  tx_cur;
   logic        last_byte;

   // Map the byte index onto a logical step; 8-bit addressing skips the high address byte.
   always_comb begin
      step = idx_q;
      if (!mode16_q && (idx_q != 3'd0)) begin
         step = idx_q + 3'd1;
      end
   end

   always_comb begin
      cmd_cur   = 6'b0;
      tx_cur    = 8'h00;
      last_byte = 1'b0;
      case (step)
         3'd0: begin
            cmd_cur = CMD_STA | CMD_WR;
            tx_cur  = {DEV_ADDR, 1'b0};
         end
         3'd1: begin
            cmd_cur = CMD_WR;
            tx_cur  = addr_q[15:8];
         end
         3'd2: begin
            cmd_cur = CMD_WR;
            tx_cur  = addr_q[7:0];
         end
         3'd3: begin
            if (rd_mode_q) begin
               cmd_cur = CMD_STA | CMD_WR;
               tx_cur  = {DEV_ADDR, 1'b1};
            end else begin
               cmd_cur   = CMD_WR | CMD_STO;
               tx_cur    = wrdata_q;
               last_byte = 1'b1;
            end
         end
         default: begin
            cmd_cur   = CMD_RD | CMD_NACK | CMD_STO;
            tx_cur    = 8'h00;
            last_byte = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rd_mode_d = rd_mode_q;
      mode16_d  = mode16_q;
      addr_d    = addr_q;
      wrdata_d  = wrdata_q;
      rddata_d  = rddata_q;
      ack_d     = ack_q;
      case (state_q)
         S_IDLE: begin
            if (wrreg_req || rdreg_req) begin
               rd_mode_d = !wrreg_req;
               mode16_d  = addr_mode;
               addr_d    = addr;
               wrdata_d  = wrdata;
               ack_d     = 1'b0;
               idx_d     = 3'd0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (Trans_Done) begin
               if (cmd_cur[0]) begin
                  ack_d = ack_q | ack_o;
               end
               if (cmd_cur[2]) begin
                  rddata_d = Rx_DATA;
               end
               if (last_byte) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: begin
            idx_d   = 3'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= 3'd0;
         rd_mode_q <= 1'b0;
         mode16_q  <= 1'b0;
         addr_q    <= 16'h0000;
         wrdata_q  <= 8'h00;
         rddata_q  <= 8'h00;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rd_mode_q <= rd_mode_d;
         mode16_q  <= mode16_d;
         addr_q    <= addr_d;
         wrdata_q  <= wrdata_d;
         rddata_q  <= rddata_d;
         ack_q     <= ack_d;
      end
   end

   // Byte outputs derive from the registered state so they hold steady across WAIT.
   assign Go      = (state_q == S_ISSUE);
   assign Cmd     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? cmd_cur : 6'b0;
   assign Tx_DATA = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? tx_cur : 8'h00;
   assign RW_Done = (state_q == S_DONE);
   assign busy    = (state_q != S_IDLE);
   assign ack     = ack_q;
   assign rddata  = rddata_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb/tb_i2c_reg_ctrl.sv - directed self-checking bench for i2c_reg_ctrl
// The initial block plays the bit-shift stage and checks each byte command by hand-computed values.
module tb_i2c_reg_ctrl;

   logic        Clk;
   logic        Rst_n;
   logic        wrreg_req;
   logic        rdreg_req;
   logic [15:0] addr;
   logic        addr_mode;
   logic [7:0]  wrdata;
   logic [7:0]  rddata;
   logic        RW_Done;
   logic        ack;
   logic        busy;
   logic [5:0]  Cmd;
   logic        Go;
   logic [7:0]  Tx_DATA;
   logic [7:0]  Rx_DATA;
   logic        Trans_Done;
   logic        ack_o;

   int tests;
   int fails;
   int go_cnt;
   int done_cnt;
   int g0;
   int d0;

   i2c_reg_ctrl #(.DEV_ADDR(7'h50)) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .wrreg_req(wrreg_req),
      .rdreg_req(rdreg_req),
      .addr(addr),
      .addr_mode(addr_mode),
      .wrdata(wrdata),
      .rddata(rddata),
      .RW_Done(RW_Done),
      .ack(ack),
      .busy(busy),
      .Cmd(Cmd),
      .Go(Go),
      .Tx_DATA(Tx_DATA),
      .Rx_DATA(Rx_DATA),
      .Trans_Done(Trans_Done),
      .ack_o(ack_o)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(negedge Clk) begin
      if (Go) go_cnt++;
      if (RW_Done) done_cnt++;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic wr, input logic rd, input logic [15:0] a,
                            input logic m, input logic [7:0] d);
      wrreg_req = wr;
      rdreg_req = rd;
      addr      = a;
      addr_mode = m;
      wrdata    = d;
      @(negedge Clk);
      wrreg_req = 1'b0;
      rdreg_req = 1'b0;
   endtask

   task automatic expect_go(input string tag, input logic [5:0] c, input logic [7:0] t);
      int n;
      n = 0;
      while (!Go && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check({tag, "_go"}, {15'd0, Go}, 16'd1);
      check({tag, "_cmd"}, {10'd0, Cmd}, {10'd0, c});
      check({tag, "_tx"}, {8'd0, Tx_DATA}, {8'd0, t});
   endtask

   task automatic respond(input int dly, input logic nack, input logic [7:0] rx, input bit chk);
      logic [5:0] c0;
      logic [7:0] t0;
      int bad;
      c0  = Cmd;
      t0  = Tx_DATA;
      bad = 0;
      @(negedge Clk);
      for (int i = 0; i < dly; i++) begin
         if (Cmd !== c0 || Tx_DATA !== t0 || Go !== 1'b0) bad++;
         @(negedge Clk);
      end
      if (chk) check("hold_stable_bad_cycles", bad[15:0], 16'd0);
      Trans_Done = 1'b1;
      ack_o      = nack;
      Rx_DATA    = rx;
      @(negedge Clk);
      Trans_Done = 1'b0;
      ack_o      = 1'b0;
      Rx_DATA    = 8'h00;
   endtask

   task automatic expect_done(input string tag, input logic exp_ack, input bit inject);
      int n;
      n = 0;
      while (!RW_Done && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check({tag, "_done"}, {15'd0, RW_Done}, 16'd1);
      check({tag, "_ack"}, {15'd0, ack}, {15'd0, exp_ack});
      check({tag, "_busy_at_done"}, {15'd0, busy}, 16'd1);
      if (inject) rdreg_req = 1'b1;
      @(negedge Clk);
      rdreg_req = 1'b0;
      check({tag, "_done_pulse_end"}, {15'd0, RW_Done}, 16'd0);
      check({tag, "_busy_after"}, {15'd0, busy}, 16'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      go_cnt = 0;
      done_cnt = 0;
      Rst_n = 1'b0;
      wrreg_req = 1'b0;
      rdreg_req = 1'b0;
      addr = 16'h0000;
      addr_mode = 1'b0;
      wrdata = 8'h00;
      Rx_DATA = 8'h00;
      Trans_Done = 1'b0;
      ack_o = 1'b0;

      // reset values
      repeat (2) @(negedge Clk);
      check("rst_go", {15'd0, Go}, 16'd0);
      check("rst_cmd", {10'd0, Cmd}, 16'd0);
      check("rst_tx", {8'd0, Tx_DATA}, 16'd0);
      check("rst_rddata", {8'd0, rddata}, 16'd0);
      check("rst_done", {15'd0, RW_Done}, 16'd0);
      check("rst_ack", {15'd0, ack}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      Rst_n = 1'b1;
      @(negedge Clk);

      // write, 8-bit address, all ACK
      #1 g0 = go_cnt; d0 = done_cnt;
      @(negedge Clk);
      drive_req(1'b1, 1'b0, 16'h0012, 1'b0, 8'hA5);
      expect_go("w8_b0", 6'h03, 8'hA0);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("w8_b1", 6'h01, 8'h12);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("w8_b2", 6'h09, 8'hA5);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_done("w8", 1'b0, 1'b0);
      #1;
      check("w8_go_count", 16'(go_cnt - g0), 16'd3);
      check("w8_done_count", 16'(done_cnt - d0), 16'd1);
      check("w8_rddata_kept", {8'd0, rddata}, 16'd0);

      // read, 16-bit address
      @(negedge Clk);
      #1 g0 = go_cnt;
      @(negedge Clk);
      drive_req(1'b0, 1'b1, 16'h3456, 1'b1, 8'h00);
      expect_go("r16_b0", 6'h03, 8'hA0);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("r16_b1", 6'h01, 8'h34);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("r16_b2", 6'h01, 8'h56);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("r16_b3", 6'h03, 8'hA1);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("r16_b4", 6'h2C, 8'h00);
      respond(0, 1'b1, 8'h5C, 1'b0);
      expect_done("r16", 1'b0, 1'b0);
      #1;
      check("r16_go_count", 16'(go_cnt - g0), 16'd5);
      check("r16_rddata", {8'd0, rddata}, 16'h005C);

      // read, 8-bit address
      @(negedge Clk);
      drive_req(1'b0, 1'b1, 16'hFF77, 1'b0, 8'h00);
      expect_go("r8_b0", 6'h03, 8'hA0);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("r8_b1", 6'h01, 8'h77);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("r8_b2", 6'h03, 8'hA1);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("r8_b3", 6'h2C, 8'h00);
      respond(0, 1'b1, 8'h3E, 1'b0);
      expect_done("r8", 1'b0, 1'b0);
      check("r8_rddata", {8'd0, rddata}, 16'h003E);

      // write, device address NACKed; sequence still completes with STOP
      @(negedge Clk);
      drive_req(1'b1, 1'b0, 16'h0020, 1'b0, 8'h11);
      expect_go("nk_b0", 6'h03, 8'hA0);
      respond(0, 1'b1, 8'h00, 1'b0);
      expect_go("nk_b1", 6'h01, 8'h20);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("nk_b2", 6'h09, 8'h11);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_done("nk", 1'b1, 1'b0);
      repeat (3) @(negedge Clk);
      check("nk_ack_sticky_idle", {15'd0, ack}, 16'd1);
      check("nk_rddata_kept", {8'd0, rddata}, 16'h003E);

      // simultaneous requests, read while busy, request during DONE
      #1 g0 = go_cnt; d0 = done_cnt;
      @(negedge Clk);
      drive_req(1'b1, 1'b1, 16'h0040, 1'b0, 8'h77);
      check("both_ack_cleared", {15'd0, ack}, 16'd0);
      expect_go("both_b0", 6'h03, 8'hA0);
      rdreg_req = 1'b1;
      @(negedge Clk);
      rdreg_req = 1'b0;
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("both_b1", 6'h01, 8'h40);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("both_b2", 6'h09, 8'h77);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_done("both", 1'b0, 1'b1);
      repeat (20) @(negedge Clk);
      #1;
      check("both_go_count", 16'(go_cnt - g0), 16'd3);
      check("both_done_count", 16'(done_cnt - d0), 16'd1);
      check("both_idle_busy", {15'd0, busy}, 16'd0);

      // reset during WAIT of the second byte
      @(negedge Clk);
      #1 d0 = done_cnt;
      @(negedge Clk);
      drive_req(1'b1, 1'b0, 16'h0099, 1'b0, 8'h42);
      expect_go("ar_b0", 6'h03, 8'hA0);
      respond(0, 1'b1, 8'h00, 1'b0);
      expect_go("ar_b1", 6'h01, 8'h99);
      @(negedge Clk);
      check("ar_ack_before", {15'd0, ack}, 16'd1);
      #2 Rst_n = 1'b0;
      #1;
      check("ar_go", {15'd0, Go}, 16'd0);
      check("ar_cmd", {10'd0, Cmd}, 16'd0);
      check("ar_tx", {8'd0, Tx_DATA}, 16'd0);
      check("ar_rddata", {8'd0, rddata}, 16'd0);
      check("ar_done", {15'd0, RW_Done}, 16'd0);
      check("ar_ack", {15'd0, ack}, 16'd0);
      check("ar_busy", {15'd0, busy}, 16'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      #1;
      check("ar_no_done", 16'(done_cnt - d0), 16'd0);
      @(negedge Clk);
      drive_req(1'b1, 1'b0, 16'h0001, 1'b0, 8'hC3);
      expect_go("ar2_b0", 6'h03, 8'hA0);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("ar2_b1", 6'h01, 8'h01);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("ar2_b2", 6'h09, 8'hC3);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_done("ar2", 1'b0, 1'b0);

      // Trans_Done held off for 1000 cycles
      #1 g0 = go_cnt;
      @(negedge Clk);
      drive_req(1'b1, 1'b0, 16'h0005, 1'b0, 8'h5A);
      expect_go("dl_b0", 6'h03, 8'hA0);
      respond(1000, 1'b0, 8'h00, 1'b1);
      expect_go("dl_b1", 6'h01, 8'h05);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_go("dl_b2", 6'h09, 8'h5A);
      respond(0, 1'b0, 8'h00, 1'b0);
      expect_done("dl", 1'b0, 1'b0);
      #1;
      check("dl_go_count", 16'(go_cnt - g0), 16'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
